// File: rtl/bca_pkg.sv
// Shared definitions for the bit-count (BCA) family: state encoding of the
// pattern generator controller and the default word width.
package bca_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } pg_state_t;

   localparam int BCA_WIDTH = 8;

endpackage : bca_pkg

// File: rtl/pattern_gen_datapath.sv
// Pattern shift register, remaining-ones counter and out-of-range flag.
// Ones are shifted in first, so after WIDTH shifts they sit at the MSB end.
module pattern_gen_datapath
   import bca_pkg::*;
#(
   parameter int WIDTH = BCA_WIDTH,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [CW-1:0]    count_i,
   output logic [WIDTH-1:0] pattern_o,
   output logic             zero_o,
   output logic             err_flag_o
);

   logic [WIDTH-1:0] pattern_q, pattern_d;
   logic [CW-1:0]    remaining_q, remaining_d;
   logic             err_flag_q, err_flag_d;
   logic             zero_s;

   // Requests above WIDTH saturate so the word simply fills with ones.
   function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] k);
      logic [CW-1:0] r;
      if (k > CW'(WIDTH)) begin
         r = CW'(WIDTH);
      end else begin
         r = k;
      end
      return r;
   endfunction

   assign zero_s = (remaining_q == {CW{1'b0}});

   // Next-state for the shift register, counter and error flag.
   always_comb begin
      pattern_d   = pattern_q;
      remaining_d = remaining_q;
      err_flag_d  = err_flag_q;
      if (load_i) begin
         pattern_d   = {WIDTH{1'b0}};
         remaining_d = sat_count(count_i);
         err_flag_d  = (count_i > CW'(WIDTH));
      end else if (shift_i) begin
         pattern_d = {pattern_q[WIDTH-2:0], ~zero_s};
         if (!zero_s) begin
            remaining_d = remaining_q - CW'(1);
         end else begin
            remaining_d = remaining_q;
         end
      end else begin
         pattern_d   = pattern_q;
         remaining_d = remaining_q;
         err_flag_d  = err_flag_q;
      end
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q   <= {WIDTH{1'b0}};
         remaining_q <= {CW{1'b0}};
         err_flag_q  <= 1'b0;
      end else begin
         pattern_q   <= pattern_d;
         remaining_q <= remaining_d;
         err_flag_q  <= err_flag_d;
      end
   end

   assign pattern_o  = pattern_q;
   assign zero_o     = zero_s;
   assign err_flag_o = err_flag_q;

endmodule : pattern_gen_datapath

// File: rtl/bca_pattern_gen.sv
// Builds a WIDTH-bit word holding k ones packed at the MSB end, using an ASM
// controller with a start/done handshake over a shift-register datapath.
module bca_pattern_gen
   import bca_pkg::*;
#(
   parameter int WIDTH = BCA_WIDTH,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CW-1:0]    count,
   output logic [WIDTH-1:0] pattern,
   output logic             busy,
   output logic             done,
   output logic             err
);

   pg_state_t     state_q, state_d;
   logic [CW-1:0] steps_q, steps_d;
   logic          busy_q, done_q, err_q;
   logic          load_s, shift_s, zero_s, err_flag_s;

   // Controller next-state and datapath control strobes.
   always_comb begin
      state_d = state_q;
      steps_d = steps_q;
      load_s  = 1'b0;
      shift_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load_s  = 1'b1;
               steps_d = {CW{1'b0}};
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            shift_s = 1'b1;
            steps_d = steps_q + CW'(1);
            if (steps_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_DONE: begin
            if (start) begin
               state_d = S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            steps_d = {CW{1'b0}};
         end
      endcase
   end

   // State, step counter and Moore outputs; outputs decode the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         steps_q <= {CW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         steps_q <= steps_d;
         busy_q  <= (state_d == S_SHIFT);
         done_q  <= (state_d == S_DONE);
         err_q   <= (state_d == S_DONE) && err_flag_s;
      end
   end

   pattern_gen_datapath #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_datapath (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load_s),
      .shift_i    (shift_s),
      .count_i    (count),
      .pattern_o  (pattern),
      .zero_o     (zero_s),
      .err_flag_o (err_flag_s)
   );

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule : bca_pattern_gen
